// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute stage: ALU opcodes,
// control-word bit positions and condition-code bit positions.
package pipeline_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_MOV  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_NOT  = 4'd6,
      OP_INC  = 4'd7,
      OP_DEC  = 4'd8,
      OP_SHL  = 4'd9,
      OP_SHR  = 4'd10,
      OP_LDM  = 4'd11,
      OP_SETC = 4'd12,
      OP_CLRC = 4'd13,
      OP_R14  = 4'd14,
      OP_R15  = 4'd15
   } alu_op_e;

   localparam int CTL_OP_LSB = 0;
   localparam int CTL_OP_MSB = 3;
   localparam int CTL_IMM    = 4;
   localparam int CTL_RW     = 5;
   localparam int CTL_MR     = 6;
   localparam int CTL_MW     = 7;

   localparam int CCR_C = 2;
   localparam int CCR_N = 1;
   localparam int CCR_Z = 0;

   function automatic logic [2:0] wb_ctrl(input logic [7:0] ctl);
      return {ctl[CTL_MW], ctl[CTL_MR], ctl[CTL_RW]};
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side inputs and memory-side outputs of the execute stage.
// The driver uses master, the stage itself uses slave.
interface execute_stage_if #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 3
);
   logic [DATA_W-1:0]  imm_value_execute;
   logic [4:0]         shmnt_execute;
   logic [DATA_W-1:0]  rs_data_execute;
   logic [DATA_W-1:0]  rd_data_execute;
   logic [RADDR_W-1:0] rd_execute;
   logic [7:0]         control_signals_execute;
   logic               stall;
   logic               flush;

   logic [DATA_W-1:0]  alu_result_mem;
   logic [DATA_W-1:0]  store_data_mem;
   logic [RADDR_W-1:0] rd_mem;
   logic [2:0]         wb_ctrl_mem;
   logic [2:0]         ccr;

   modport master (
      output imm_value_execute, shmnt_execute, rs_data_execute,
      output rd_data_execute, rd_execute, control_signals_execute,
      output stall, flush,
      input  alu_result_mem, store_data_mem, rd_mem, wb_ctrl_mem, ccr
   );

   modport slave (
      input  imm_value_execute, shmnt_execute, rs_data_execute,
      input  rd_data_execute, rd_execute, control_signals_execute,
      input  stall, flush,
      output alu_result_mem, store_data_mem, rd_mem, wb_ctrl_mem, ccr
   );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result, candidate flags and flag-update enables.
// Arithmetic and shifts run one bit wider so the carry/borrow falls out.
module alu_core
   import pipeline_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] imm_i,
   input  alu_op_e           op_i,
   input  logic [4:0]        shmnt_i,
   input  logic              c_i,
   output logic [DATA_W-1:0] result_o,
   output logic              c_o,
   output logic              n_o,
   output logic              z_o,
   output logic              zn_en_o,
   output logic              c_en_o
);

   localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

   logic [DATA_W:0] a_w;
   logic [DATA_W:0] b_w;
   logic [DATA_W:0] add_w;
   logic [DATA_W:0] sub_w;
   logic [DATA_W:0] inc_w;
   logic [DATA_W:0] dec_w;
   logic [DATA_W:0] shl_w;
   logic [DATA_W:0] shr_w;
   logic            sh_zero;

   assign a_w     = {1'b0, a_i};
   assign b_w     = {1'b0, b_i};
   assign add_w   = a_w + b_w;
   assign sub_w   = a_w - b_w;
   assign inc_w   = a_w + ONE;
   assign dec_w   = a_w - ONE;
   // Over-range shifts drain every bit, giving result 0 and C 0.
   assign shl_w   = a_w << shmnt_i;
   assign shr_w   = {a_i, 1'b0} >> shmnt_i;
   assign sh_zero = (shmnt_i == 5'd0);

   always_comb begin
      result_o = '0;
      c_o      = c_i;
      zn_en_o  = 1'b0;
      c_en_o   = 1'b0;
      case (op_i)
         OP_MOV: result_o = b_i;
         OP_ADD: begin
            result_o = add_w[DATA_W-1:0];
            c_o      = add_w[DATA_W];
            zn_en_o  = 1'b1;
            c_en_o   = 1'b1;
         end
         OP_SUB: begin
            result_o = sub_w[DATA_W-1:0];
            c_o      = sub_w[DATA_W];
            zn_en_o  = 1'b1;
            c_en_o   = 1'b1;
         end
         OP_AND: begin
            result_o = a_i & b_i;
            zn_en_o  = 1'b1;
         end
         OP_OR: begin
            result_o = a_i | b_i;
            zn_en_o  = 1'b1;
         end
         OP_NOT: begin
            result_o = ~a_i;
            zn_en_o  = 1'b1;
         end
         OP_INC: begin
            result_o = inc_w[DATA_W-1:0];
            c_o      = inc_w[DATA_W];
            zn_en_o  = 1'b1;
            c_en_o   = 1'b1;
         end
         OP_DEC: begin
            result_o = dec_w[DATA_W-1:0];
            c_o      = dec_w[DATA_W];
            zn_en_o  = 1'b1;
            c_en_o   = 1'b1;
         end
         OP_SHL: begin
            result_o = shl_w[DATA_W-1:0];
            c_o      = shl_w[DATA_W];
            zn_en_o  = 1'b1;
            c_en_o   = ~sh_zero;
         end
         OP_SHR: begin
            result_o = shr_w[DATA_W:1];
            c_o      = shr_w[0];
            zn_en_o  = 1'b1;
            c_en_o   = ~sh_zero;
         end
         OP_LDM: result_o = imm_i;
         OP_SETC: begin
            c_o    = 1'b1;
            c_en_o = 1'b1;
         end
         OP_CLRC: begin
            c_o    = 1'b0;
            c_en_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign n_o = result_o[DATA_W-1];
   assign z_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand select, ALU, and the EX/MEM register with CCR.
// Priority at each edge is rst, then flush, then stall.
module execute_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 3
) (
   input logic             clk,
   input logic             rst,
   execute_stage_if.slave  ex
);

   logic [DATA_W-1:0]  opnd_a;
   logic [DATA_W-1:0]  opnd_b;
   alu_op_e            op;
   logic [DATA_W-1:0]  alu_res;
   logic               alu_c;
   logic               alu_n;
   logic               alu_z;
   logic               zn_en;
   logic               c_en;

   logic [DATA_W-1:0]  res_q, res_d;
   logic [DATA_W-1:0]  sd_q, sd_d;
   logic [RADDR_W-1:0] rd_q, rd_d;
   logic [2:0]         wb_q, wb_d;
   logic [2:0]         ccr_q, ccr_d;

   assign op     = alu_op_e'(ex.control_signals_execute[CTL_OP_MSB:CTL_OP_LSB]);
   assign opnd_a = ex.rd_data_execute;
   assign opnd_b = ex.control_signals_execute[CTL_IMM] ?
                   ex.imm_value_execute : ex.rs_data_execute;

   alu_core #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a_i      (opnd_a),
      .b_i      (opnd_b),
      .imm_i    (ex.imm_value_execute),
      .op_i     (op),
      .shmnt_i  (ex.shmnt_execute),
      .c_i      (ccr_q[CCR_C]),
      .result_o (alu_res),
      .c_o      (alu_c),
      .n_o      (alu_n),
      .z_o      (alu_z),
      .zn_en_o  (zn_en),
      .c_en_o   (c_en)
   );

   always_comb begin
      res_d = res_q;
      sd_d  = sd_q;
      rd_d  = rd_q;
      wb_d  = wb_q;
      ccr_d = ccr_q;
      if (ex.flush) begin
         res_d = '0;
         sd_d  = '0;
         rd_d  = '0;
         wb_d  = '0;
      end else if (!ex.stall) begin
         res_d = alu_res;
         sd_d  = ex.rd_data_execute;
         rd_d  = ex.rd_execute;
         wb_d  = wb_ctrl(ex.control_signals_execute);
         if (zn_en) begin
            ccr_d[CCR_N] = alu_n;
            ccr_d[CCR_Z] = alu_z;
         end
         if (c_en) begin
            ccr_d[CCR_C] = alu_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= '0;
         sd_q  <= '0;
         rd_q  <= '0;
         wb_q  <= '0;
         ccr_q <= '0;
      end else begin
         res_q <= res_d;
         sd_q  <= sd_d;
         rd_q  <= rd_d;
         wb_q  <= wb_d;
         ccr_q <= ccr_d;
      end
   end

   assign ex.alu_result_mem = res_q;
   assign ex.store_data_mem = sd_q;
   assign ex.rd_mem         = rd_q;
   assign ex.wb_ctrl_mem    = wb_q;
   assign ex.ccr            = ccr_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases then random traffic,
// every edge compared against an integer reference model.
module tb_execute_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   execute_stage_if ex ();

   execute_stage dut (
      .clk (clk),
      .rst (rst),
      .ex  (ex.slave)
   );

   int passed = 0;
   int total  = 0;

   logic [15:0] m_res, m_sd;
   logic [2:0]  m_rd, m_wb, m_ccr;

   task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
   endtask

   task automatic model();
      int a, b, r, op, sh, imm;
      bit c, zn, cu;
      if (rst) begin
         m_res = 0; m_sd = 0; m_rd = 0; m_wb = 0; m_ccr = 0;
      end else if (ex.flush) begin
         m_res = 0; m_sd = 0; m_rd = 0; m_wb = 0;
      end else if (!ex.stall) begin
         imm = int'(ex.imm_value_execute);
         a   = int'(ex.rd_data_execute);
         b   = ex.control_signals_execute[4] ? imm : int'(ex.rs_data_execute);
         op  = int'(ex.control_signals_execute[3:0]);
         sh  = int'(ex.shmnt_execute);
         c   = m_ccr[2];
         zn  = 0; cu = 0; r = 0;
         case (op)
            1: r = b;
            2: begin r = a + b; c = (r > 65535); zn = 1; cu = 1; end
            3: begin r = a - b; c = (a < b); zn = 1; cu = 1; end
            4: begin r = a & b; zn = 1; end
            5: begin r = a | b; zn = 1; end
            6: begin r = 65535 - a; zn = 1; end
            7: begin r = a + 1; c = (a == 65535); zn = 1; cu = 1; end
            8: begin r = a - 1; c = (a == 0); zn = 1; cu = 1; end
            9, 10: begin
               zn = 1;
               if (sh == 0) r = a;
               else if (sh > 16) begin r = 0; c = 0; cu = 1; end
               else if (op == 9) begin
                  r = a << sh; c = ((a >> (16 - sh)) & 1) != 0; cu = 1;
               end else begin
                  r = a >> sh; c = ((a >> (sh - 1)) & 1) != 0; cu = 1;
               end
            end
            11: r = imm;
            12: begin c = 1; cu = 1; end
            13: begin c = 0; cu = 1; end
            default: r = 0;
         endcase
         r = r & 32'hFFFF;
         m_res = r[15:0];
         m_sd  = ex.rd_data_execute;
         m_rd  = ex.rd_execute;
         m_wb  = ex.control_signals_execute[7:5];
         if (zn) begin
            m_ccr[1] = r[15];
            m_ccr[0] = (r == 0);
         end
         if (cu) m_ccr[2] = c;
      end
   endtask

   task automatic tick(string tag);
      model();
      @(posedge clk);
      #1;
      chk({tag, ".res"}, ex.alu_result_mem, m_res);
      chk({tag, ".sd"},  ex.store_data_mem, m_sd);
      chk({tag, ".rd"},  {13'd0, ex.rd_mem}, {13'd0, m_rd});
      chk({tag, ".wb"},  {13'd0, ex.wb_ctrl_mem}, {13'd0, m_wb});
      chk({tag, ".ccr"}, {13'd0, ex.ccr}, {13'd0, m_ccr});
   endtask

   task automatic drv(input logic [3:0] op, input logic isel,
                      input logic [15:0] a, input logic [15:0] rs,
                      input logic [15:0] imm, input logic [4:0] sh,
                      input logic [2:0] rd, input logic [2:0] wb);
      ex.control_signals_execute = {wb, isel, op};
      ex.rd_data_execute   = a;
      ex.rs_data_execute   = rs;
      ex.imm_value_execute = imm;
      ex.shmnt_execute     = sh;
      ex.rd_execute        = rd;
      ex.stall = 1'b0;
      ex.flush = 1'b0;
   endtask

   function automatic logic [15:0] rval();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic rnd_drive();
      drv(4'($urandom_range(0, 15)), 1'($urandom), rval(), rval(),
          rval(), 5'($urandom_range(0, 20)), 3'($urandom), 3'($urandom));
   endtask

   logic [15:0] hold_res;
   logic [2:0]  hold_ccr;

   initial begin
      rst = 1'b1;
      drv(4'd2, 1'b0, 16'h1234, 16'h1111, 16'h5555, 5'd3, 3'd5, 3'b111);
      tick("reset");
      chk("reset.ccr0", {13'd0, ex.ccr}, 16'h0000);
      rst = 1'b0;

      drv(4'd2, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 5'd0, 3'd1, 3'b001);
      tick("add");
      chk("add.const", ex.alu_result_mem, 16'h0000);
      chk("add.ccr",   {13'd0, ex.ccr}, 16'h0005);

      drv(4'd3, 1'b1, 16'h0003, 16'h7777, 16'h0005, 5'd0, 3'd2, 3'b001);
      tick("subi");
      chk("subi.const", ex.alu_result_mem, 16'hFFFE);
      chk("subi.ccr",   {13'd0, ex.ccr}, 16'h0006);

      drv(4'd9, 1'b0, 16'h8001, 16'h0, 16'h0, 5'd1, 3'd3, 3'b001);
      tick("shl1");
      chk("shl1.const", ex.alu_result_mem, 16'h0002);
      chk("shl1.c", {15'd0, ex.ccr[2]}, 16'h0001);
      drv(4'd9, 1'b0, 16'h8001, 16'h0, 16'h0, 5'd17, 3'd3, 3'b001);
      tick("shl17");
      chk("shl17.ccr", {13'd0, ex.ccr}, 16'h0001);
      drv(4'd12, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 3'd0, 3'b000);
      tick("setc");
      drv(4'd9, 1'b0, 16'h8001, 16'h0, 16'h0, 5'd0, 3'd3, 3'b001);
      tick("shl0");
      chk("shl0.const", ex.alu_result_mem, 16'h8001);
      chk("shl0.ccr",   {13'd0, ex.ccr}, 16'h0006);

      drv(4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 3'd6, 3'b110);
      tick("nop_wb");
      drv(4'd15, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 3'd7, 3'b101);
      tick("undef_wb");

      drv(4'd5, 1'b0, 16'h00F0, 16'h0F00, 16'h0, 5'd0, 3'd4, 3'b001);
      tick("or");
      hold_res = ex.alu_result_mem;
      hold_ccr = ex.ccr;
      for (int i = 0; i < 2; i++) begin
         rnd_drive();
         ex.stall = 1'b1;
         tick("stall");
         chk("stall.res", ex.alu_result_mem, hold_res);
         chk("stall.ccr", {13'd0, ex.ccr}, {13'd0, hold_ccr});
      end
      rnd_drive();
      ex.stall = 1'b1;
      ex.flush = 1'b1;
      tick("flush");
      chk("flush.wb", {13'd0, ex.wb_ctrl_mem}, 16'h0000);
      chk("flush.ccr", {13'd0, ex.ccr}, {13'd0, hold_ccr});

      for (int i = 0; i < 3; i++) begin
         drv(4'd2, 1'b0, 16'h8000, 16'h8001, 16'h0, 5'd0, 3'd2, 3'b001);
         tick("adds");
      end
      rst = 1'b1;
      tick("midrst");
      chk("midrst.ccr", {13'd0, ex.ccr}, 16'h0000);
      rst = 1'b0;

      drv(4'd12, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0, 3'd0, 3'b000);
      tick("setc2");
      drv(4'd11, 1'b1, 16'h1234, 16'h0, 16'h0000, 5'd0, 3'd1, 3'b001);
      tick("ldm0");
      chk("ldm0.ccr", {13'd0, ex.ccr}, 16'h0004);

      for (int i = 0; i < 400; i++) begin
         rnd_drive();
         ex.stall = ($urandom_range(0, 5) == 0);
         ex.flush = ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 39) == 0);
         tick("rand");
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
